// File: rtl/cla_seq_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer: state encoding,
// datapath slice width and the byte-count helper.
package cla_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned BYTE_W = 8;

    function automatic int unsigned nbyte(input int unsigned width);
        return width / BYTE_W;
    endfunction

endpackage

// File: rtl/cla_seq_32bit_if.sv
// Request/result bundle for cla_seq_32bit. The ovf signal exists only when
// CLA_SEQ_OVF_EN is defined.
interface cla_seq_32bit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             op_sub;
    logic             ci;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
`ifdef CLA_SEQ_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, op_sub, ci, a, b,
`ifdef CLA_SEQ_OVF_EN
        input  ovf,
`endif
        input  busy, done, s, co
    );

    modport slave (
        input  start, op_sub, ci, a, b,
`ifdef CLA_SEQ_OVF_EN
        output ovf,
`endif
        output busy, done, s, co
    );

endinterface

// File: rtl/cla_8bit.sv
// 8-bit carry-lookahead adder: every carry is a flat sum-of-products of the
// generate/propagate terms and the carry-in, not a ripple chain.
module cla_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       ci_i,
    output logic [7:0] s_o,
    output logic       co_o
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        logic acc;
        logic pp;
        c    = '0;
        c[0] = ci_i;
        for (int i = 0; i < 8; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & ci_i);
        end
    end

    assign s_o  = p ^ c[7:0];
    assign co_o = c[8];

endmodule

// File: rtl/cla_seq_32bit.sv
// Byte-serial WIDTH-bit add/subtract sequencer sharing one cla_8bit across NBYTE
// cycles, LSB byte first. Define CLA_SEQ_OVF_EN to add the signed-overflow flag.
module cla_seq_32bit
    import cla_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    cla_seq_32bit_if.slave bus
);

    localparam int unsigned NBYTE = nbyte(WIDTH);
    localparam int unsigned IdxW  = (NBYTE > 1) ? $clog2(NBYTE) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTE - 1);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              co_q, co_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef CLA_SEQ_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic [BYTE_W-1:0] byte_a;
    logic [BYTE_W-1:0] byte_b;
    logic [BYTE_W-1:0] byte_s;
    logic              byte_co;

    assign byte_a = a_q[idx_q*BYTE_W +: BYTE_W];
    assign byte_b = b_q[idx_q*BYTE_W +: BYTE_W];

    cla_8bit u_cla (
        .a_i  (byte_a),
        .b_i  (byte_b),
        .ci_i (carry_q),
        .s_o  (byte_s),
        .co_o (byte_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        co_d    = co_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef CLA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1, so invert b and force the carry-in.
                    a_d     = bus.a;
                    b_d     = bus.op_sub ? ~bus.b : bus.b;
                    carry_d = bus.op_sub ? 1'b1 : bus.ci;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                s_d[idx_q*BYTE_W +: BYTE_W] = byte_s;
                carry_d = byte_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    co_d    = byte_co;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
`ifdef CLA_SEQ_OVF_EN
                    ovf_d   = (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (byte_s[BYTE_W-1] ^ a_q[WIDTH-1]);
`endif
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.co   = co_q;
`ifdef CLA_SEQ_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_32bit.sv
// Self-checking bench for cla_seq_32bit: directed vector table plus hand-written
// multi-cycle sequences. Overflow checks are active when CLA_SEQ_OVF_EN is defined.
module tb_cla_seq_32bit;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op_sub;
        logic        ci;
        logic [31:0] exp_s;
        logic        exp_co;
        logic        exp_ovf;
    } vec_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    cla_seq_32bit_if #(.WIDTH(32)) bus ();

    cla_seq_32bit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // busy and done must never be high together.
    always @(negedge clk) begin
        if (reset_n && bus.busy && bus.done) begin
            failures++;
            $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both");
        end
    end

    // Accept one op, then count cycles (cycle 1 = first after accept edge) until done.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic ci, output int lat, output int busy_cnt);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.a      = a;
        bus.b      = b;
        bus.op_sub = sub;
        bus.ci     = ci;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat       = 1;
        busy_cnt  = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        vec_t vecs[10];
        int   lat;
        int   bcnt;
        int   n;
        int   dones;
        logic [31:0] s_seen;

        checks   = 0;
        failures = 0;
        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[9] = '{32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.ci     = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        reset_n    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_s", bus.s, 32'd0);
        check("reset_co", 32'(bus.co), 32'd0);
`ifdef CLA_SEQ_OVF_EN
        check("reset_ovf", 32'(bus.ovf), 32'd0);
`endif
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].op_sub, vecs[i].ci, lat, bcnt);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd4);
            check($sformatf("vec%0d_s", i), bus.s, vecs[i].exp_s);
            check($sformatf("vec%0d_co", i), 32'(bus.co), 32'(vecs[i].exp_co));
`ifdef CLA_SEQ_OVF_EN
            check($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].exp_ovf));
`endif
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
            check($sformatf("vec%0d_s_hold", i), bus.s, vecs[i].exp_s);
        end

        // Start while busy: a second request in RUN cycle 2 must be dropped.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.a      = 32'h1234_5678;
        bus.b      = 32'h1111_1111;
        bus.op_sub = 1'b0;
        bus.ci     = 1'b0;
        @(posedge clk);
        dones  = 0;
        s_seen = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (k == 2) begin
                bus.start = 1'b1;
                bus.a     = 32'hFFFF_FFFF;
                bus.b     = 32'hFFFF_FFFF;
            end
            if (k == 3) bus.start = 1'b0;
            if (bus.done) begin
                if (dones == 0) s_seen = bus.s;
                dones++;
            end
        end
        check("busy_ignore_s", s_seen, 32'h2345_6789);
        check("busy_ignore_dones", 32'(dones), 32'd1);

        // Back-to-back: start held high, second op accepted in the DONE cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h0000_0001;
        bus.b     = 32'h0000_0002;
        bus.ci    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.a  = 32'h00FF_00FF;
        bus.b  = 32'h0001_0001;
        bus.ci = 1'b1;
        n = 1;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_latency", 32'(n), 32'd5);
        check("b2b_first_s", bus.s, 32'h0000_0003);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_no_gap_busy", 32'(bus.busy), 32'd1);
        n = 1;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_latency", 32'(n), 32'd5);
        check("b2b_second_s", bus.s, 32'h0100_0101);
        check("b2b_second_co", 32'(bus.co), 32'd0);

        // Reset in RUN cycle 3: outputs clear, no done, then normal operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'h0000_0001;
        bus.ci    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_done", 32'(bus.done), 32'd0);
        check("rst_mid_s", bus.s, 32'd0);
        check("rst_mid_co", 32'(bus.co), 32'd0);
`ifdef CLA_SEQ_OVF_EN
        check("rst_mid_ovf", 32'(bus.ovf), 32'd0);
`endif
        reset_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        check("rst_mid_no_done", 32'(dones), 32'd0);
        do_op(32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0, lat, bcnt);
        check("rst_after_latency", 32'(lat), 32'd5);
        check("rst_after_s", bus.s, 32'h0000_00FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
